// File: rtl/rangefinder_leds_pkg.sv
// Shared widths and types for the rangefinder LED driver.
package rangefinder_leds_pkg;

    localparam int PWM_W = 4;
    localparam int LED_N = 8;

    typedef logic [PWM_W-1:0] led_level_t;
    typedef logic [LED_N-1:0] led_vec_t;

    localparam led_level_t PWM_MAX = '1;

endpackage

// File: rtl/rangefinder_leds_prescaler.sv
// Clock divider for the LED PWM: step tick, 16-step PWM counter and
// the period-wrap strobe (tick on which the PWM counter rolls 15->0).
module rangefinder_leds_prescaler
    import rangefinder_leds_pkg::*;
#(
    parameter int PWM_DIV = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       tick,
    output logic       wrap,
    output led_level_t pwm_cnt
);

    localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PWM_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = (div_cnt == DIV_LAST);
    assign wrap = tick && (pwm_cnt == PWM_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            pwm_cnt <= pwm_cnt + led_level_t'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/rangefinder_leds_driver.sv
// LED pin driver: global PWM dimming, per-LED blink and registered output.
// Optional per-LED fading is built when RANGEFINDER_LEDS_FADE_EN is defined.
module rangefinder_leds_driver
    import rangefinder_leds_pkg::*;
#(
    parameter int PWM_DIV    = 64,
    parameter int BLINK_DIV  = 32,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [LED_N-1:0] led_in,
    input  logic [LED_N-1:0] blink_mask,
    input  logic [PWM_W-1:0] duty,
    output logic [LED_N-1:0] led_out,
    output logic             period_start
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam led_vec_t POL = ACTIVE_LOW ? '1 : '0;

    logic       tick;
    logic       wrap;
    led_level_t pwm_cnt;
    led_level_t duty_q;
    logic [BW-1:0] blink_cnt;
    logic       blink_phase;

    logic [LED_N-1:0][PWM_W-1:0] target;
    logic [LED_N-1:0][PWM_W-1:0] level;
    led_vec_t   on_vec;

    rangefinder_leds_prescaler #(
        .PWM_DIV (PWM_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .wrap    (wrap),
        .pwm_cnt (pwm_cnt)
    );

    // duty is only taken at the period boundary so a pulse is never cut short
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q       <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b1;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (wrap) begin
                duty_q <= duty;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    always_comb begin
        target = '0;
        for (int i = 0; i < LED_N; i++) begin
            target[i] = led_in[i] ? duty_q : '0;
        end
    end

`ifdef RANGEFINDER_LEDS_FADE_EN
    function automatic led_level_t step_toward(input led_level_t cur, input led_level_t tgt);
        if (cur < tgt) begin
            return cur + led_level_t'(1);
        end else if (cur > tgt) begin
            return cur - led_level_t'(1);
        end
        return cur;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else if (wrap) begin
            for (int i = 0; i < LED_N; i++) begin
                level[i] <= step_toward(level[i], target[i]);
            end
        end
    end
`else
    always_comb begin
        level = target;
    end
`endif

    always_comb begin
        on_vec = '0;
        for (int i = 0; i < LED_N; i++) begin
            on_vec[i] = (pwm_cnt < level[i]) && (!blink_mask[i] || blink_phase);
        end
    end

    // output register stage: polarity applied at the pin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= POL;
        end else begin
            led_out <= on_vec ^ POL;
        end
    end

endmodule

// File: tb/tb_rangefinder_leds_driver.sv
// Scoreboard bench for rangefinder_leds_driver: two instances (active-high,
// PWM_DIV=1 and active-low, PWM_DIV=3) checked against a time-based model.
module tb_rangefinder_leds_driver;

    localparam int P0 = 1;
    localparam int B0 = 2;
    localparam int P1 = 3;
    localparam int B1 = 2;
    localparam int RUN_CYCLES = 4000;
    localparam int RESET_AT   = 2100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] led_in = '0;
    logic [7:0] blink_mask = '0;
    logic [3:0] duty = '0;
    logic [7:0] out0, out1;
    logic       ps0, ps1;

    typedef struct {
        int         due;
        logic [8:0] e0;
        logic [8:0] e1;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    int unsigned mt[2];
    int          mdq[2];
    int          lvl[2][8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rangefinder_leds_driver #(
        .PWM_DIV    (P0),
        .BLINK_DIV  (B0),
        .ACTIVE_LOW (1'b0)
    ) u_dut0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .led_in       (led_in),
        .blink_mask   (blink_mask),
        .duty         (duty),
        .led_out      (out0),
        .period_start (ps0)
    );

    rangefinder_leds_driver #(
        .PWM_DIV    (P1),
        .BLINK_DIV  (B1),
        .ACTIVE_LOW (1'b1)
    ) u_dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .led_in       (led_in),
        .blink_mask   (blink_mask),
        .duty         (duty),
        .led_out      (out1),
        .period_start (ps1)
    );

    function automatic void chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got {ps,led}=%h want %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mt[k]  = 0;
            mdq[k] = 0;
            for (int i = 0; i < 8; i++) lvl[k][i] = 0;
        end
    endfunction

    // Expected {period_start, led_out} after the next edge, from the state
    // index t since reset release and the inputs currently applied.
    function automatic logic [8:0] model_step(input int k, input int p, input int b, input bit al);
        int   per;
        int   pc;
        int   n;
        bit   phase;
        bit   wrp;
        int   tgt;
        int   lv;
        logic [7:0] o;
        per   = 16 * p;
        pc    = (int'(mt[k]) / p) % 16;
        n     = int'(mt[k]) / per;
        phase = ((n / b) % 2) == 0;
        wrp   = (int'(mt[k]) % per) == per - 1;
        o     = '0;
        for (int i = 0; i < 8; i++) begin
            tgt = led_in[i] ? mdq[k] : 0;
`ifndef RANGEFINDER_LEDS_FADE_EN
            lvl[k][i] = tgt;
`endif
            lv   = lvl[k][i];
            o[i] = ((pc < lv) && (!blink_mask[i] || phase)) ^ al;
`ifdef RANGEFINDER_LEDS_FADE_EN
            if (wrp) begin
                if (lvl[k][i] < tgt) lvl[k][i]++;
                else if (lvl[k][i] > tgt) lvl[k][i]--;
            end
`endif
        end
        if (wrp) mdq[k] = int'(duty);
        mt[k]++;
        return {wrp, o};
    endfunction

    // Monitor: pops every expectation whose edge has passed
    always @(posedge clk) begin : mon
        exp_t e;
        #2;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("inst0", {ps0, out0}, e.e0);
            chk("inst1", {ps1, out1}, e.e1);
        end
    end

    task automatic push_expect();
        exp_t e;
        e.due = cyc + 1;
        e.e0  = model_step(0, P0, B0, 1'b0);
        e.e1  = model_step(1, P1, B1, 1'b1);
        sb.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_i0"}, {ps0, out0}, 9'h000);
        chk({tag, "_i1"}, {ps1, out1}, 9'h0FF);
    endtask

    int hold = 0;

    task automatic pick_inputs();
        if (hold == 0) begin
            hold = int'($urandom_range(5, 80));
            case ($urandom_range(0, 4))
                0: duty = 4'd0;
                1: duty = 4'd15;
                2: duty = 4'd5;
                3: duty = 4'd12;
                default: duty = 4'($urandom);
            endcase
            led_in     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            blink_mask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        end else begin
            hold--;
            if ($urandom_range(0, 7) == 0) led_in[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) blink_mask[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) duty = 4'($urandom);
        end
    endtask

    initial begin
        led_in     = 8'hA5;
        blink_mask = 8'h0F;
        duty       = 4'd9;
        #1 reset_n = 1'b0;
        #1 check_reset_state("reset_async");
        repeat (3) @(posedge clk);
        #1 check_reset_state("reset_hold");
        model_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        for (int c = 0; c < RUN_CYCLES; c++) begin
            if (c == RESET_AT) begin
                #2 reset_n = 1'b0;
                sb.delete();
                #1 check_reset_state("reset_mid");
                repeat (2) @(posedge clk);
                #1 check_reset_state("reset_mid_hold");
                model_reset();
                reset_n = 1'b1;
            end
            pick_inputs();
            push_expect();
            @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #3;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
